mpu_matrix_loader: RTL and testbench
====================================

# mpu_matrix_loader

Input stage of the MPU datapath. It accepts signed 8-bit matrix elements one per cycle over a valid/ready stream and assembles them into a flattened 5x5 matrix (200 bits). It then holds the matrix under a valid/ready handshake until an operation stage (opposite, add, multiply, ...) consumes it. It has a single frame buffer and zero-pads short frames.

## Interface
Parameters:
- `N`, 5, matrix dimension; the element count is N*N (25)
- `W`, 8, element width in bits (two's complement)

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `in_data` holds an element
- `in_ready`  out  1  loader can accept an element
- `in_data`  in  W  signed element
- `in_last`  in  1  qualifies the final element of a frame
- `matrix`  out  W*N*N  assembled flattened matrix
- `out_valid`  out  1  `matrix` is complete and stable
- `out_ready`  in  1  consumer takes the matrix
- `elem_count`  out  5  number of elements written into the current frame
- `frame_error`  out  1  one-cycle pulse: frame overran N*N elements without `in_last`

## Operation
- Layout:
  - Element at (col,row) occupies bits [W*(row + N*col) +: W].
  - Stream element k (k = 0..24, arrival order) is written to bits [W*k +: W], so it lands at col = k/N, row = k%N.
- States: FILL, FULL.
  - `in_ready` = (state == FILL).
  - `out_valid` = (state == FULL).
- FILL:
  - On accept (`in_valid` && `in_ready`), write `in_data` to slot `elem_count`, then increment `elem_count`.
  - If `in_last` = 1 on the accept, go to FULL. Slots above the written one stay zero, which zero-pads the frame.
  - If the accept fills slot 24 and `in_last` = 0, go to FULL and pulse `frame_error` on the next cycle. Later stream elements belong to the next frame.
  - If `in_last` = 1 on slot 24, go to FULL with no error.
- FULL:
  - `matrix` is frozen and `in_data` is ignored.
  - On `out_valid` && `out_ready`: go to FILL, clear `matrix` to 0 and `elem_count` to 0, all in the same edge.
- `elem_count` saturates at 25 in FULL and never wraps within a frame.
- Reset, effective at the clock edge while `reset` = 1:
  - state = FILL, `matrix` = 0, `elem_count` = 0, `frame_error` = 0, so `in_ready` = 1 and `out_valid` = 0.
  - Reset mid-frame or in FULL discards all partial or held data.
  - Reset wins over a simultaneous handshake on either side.
- `in_data` is stored verbatim; the loader does no arithmetic on it. Sign is preserved bit-exact (for example, -1 is stored as 8'hFF).

## Timing
- Accept-to-write latency is 1 cycle: the element is visible in `matrix` on the edge after the accept.
- The accept of the final element (`in_last`, or slot 24) makes `out_valid` = 1 on the next cycle. `in_ready` drops in the same cycle.
- Minimum frame period is 25 accept cycles plus 1 output-handshake cycle. No element can be accepted in the cycle `out_valid` is high, because the buffer is single.
- A handshake at edge t gives `in_ready` = 1 with `matrix` = 0 at t+1, so the first element of the next frame can be accepted at t+1.
- `frame_error` is high for exactly the one cycle in which `out_valid` first rises for the overrun frame.
- `out_valid` stays high and `matrix` stays stable until the handshake, regardless of `out_ready` history. `out_ready` without `out_valid` has no effect.
- `in_valid` is sampled only when `in_ready` = 1. There is no combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`.

## Test plan
- Full frame: stream 2,-1,0,4,5,12,...,1 (25 elements), `in_last` on the 25th, `out_ready` = 1.
  - `out_valid` rises 1 cycle after the 25th accept.
  - `matrix[0+:8]` = 8'h02, `matrix[8+:8]` = 8'hFF, `matrix[192+:8]` = 8'h01.
  - `frame_error` = 0.
  - `in_ready` returns the cycle after the handshake.
- Short frame: 3 elements (7,8,9) with `in_last` on the 3rd.
  - `out_valid` = 1 with bits [23:0] = 24'h090807 and all higher bits 0.
  - `elem_count` = 3.
- Overrun: 25 elements with `in_last` = 0 throughout.
  - `out_valid` = 1 and `frame_error` pulses exactly 1 cycle.
  - A 26th element offered while FULL is not accepted. After the handshake it becomes slot 0 of the next frame.
- Backpressure:
  - Hold `out_ready` = 0 for 10 cycles after FULL while driving `in_valid` = 1 with changing data. `matrix`, `out_valid` = 1 and `in_ready` = 0 stay unchanged.
  - Toggle `in_valid` randomly during FILL. Only accepted beats are written, in order.
- Reset mid-frame: load 12 elements, then assert `reset` for 1 cycle.
  - Next cycle: `matrix` = 0, `elem_count` = 0, `in_ready` = 1, `out_valid` = 0.
  - A fresh full frame then loads correctly.
- Back-to-back: two full frames with `out_ready` = 1 and `in_valid` = 1 continuously.
  - Second frame starts at slot 0 with no residue from the first frame.
  - Throughput is 26 cycles per frame.

Source files
------------

// File: rtl/mpu_matrix_loader_if.sv
// Stream-in / matrix-out handshake bundle for the MPU matrix loader.
// The slave side is the loader; the master side is the element producer plus the matrix consumer.
interface mpu_matrix_loader_if #(
    parameter int N = 5,
    parameter int W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic [W*N*N-1:0] matrix;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, matrix, out_valid
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, matrix, out_valid
    );
endinterface

// File: rtl/mpu_matrix_loader.sv
// Assembles a stream of W-bit elements into a flattened NxN matrix held in a single
// frame buffer, zero-padding short frames and flagging frames that overrun N*N elements.
module mpu_matrix_loader #(
    parameter int  N  = 5,
    parameter int  W  = 8,
    localparam int NE = N * N,
    localparam int CW = $clog2(NE + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    mpu_matrix_loader_if.slave    bus,
    output logic [CW-1:0]         elem_count,
    output logic                  frame_error
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [W*NE-1:0] matrix_r;
    logic [W*NE-1:0] matrix_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_s;
    logic            frame_error_r;
    logic            frame_error_s;
    logic            accept_s;
    logic            last_slot_s;

    assign accept_s    = bus.in_valid && (state_r == ST_FILL);
    assign last_slot_s = (count_r == CW'(NE - 1));

    // Next-state logic: write accepted elements in arrival order, release the frame on handshake.
    always_comb begin
        state_s       = state_r;
        matrix_s      = matrix_r;
        count_s       = count_r;
        frame_error_s = 1'b0;
        case (state_r)
            ST_FILL: begin
                if (accept_s) begin
                    for (int k = 0; k < NE; k++) begin
                        if (count_r == CW'(k)) begin
                            matrix_s[W*k +: W] = bus.in_data;
                        end else begin
                            matrix_s[W*k +: W] = matrix_r[W*k +: W];
                        end
                    end
                    count_s = count_r + CW'(1);
                    // Filling the last slot closes the frame even without in_last; that is the overrun case.
                    if (bus.in_last || last_slot_s) begin
                        state_s       = ST_FULL;
                        frame_error_s = ~bus.in_last;
                    end else begin
                        state_s = ST_FILL;
                    end
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_FULL: begin
                if (bus.out_ready) begin
                    state_s  = ST_FILL;
                    matrix_s = '0;
                    count_s  = '0;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s  = ST_FILL;
                matrix_s = '0;
                count_s  = '0;
            end
        endcase
    end

    // State and frame buffer registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_FILL;
            matrix_r      <= '0;
            count_r       <= '0;
            frame_error_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            matrix_r      <= matrix_s;
            count_r       <= count_s;
            frame_error_r <= frame_error_s;
        end
    end

    assign bus.in_ready  = (state_r == ST_FILL);
    assign bus.out_valid = (state_r == ST_FULL);
    assign bus.matrix    = matrix_r;
    assign elem_count    = count_r;
    assign frame_error   = frame_error_r;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed and randomized bench for mpu_matrix_loader against a frame-level queue model.
module tb_mpu_matrix_loader;
    localparam int N  = 5;
    localparam int W  = 8;
    localparam int NE = N * N;
    localparam int MW = W * NE;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] elem_count;
    logic       frame_error;

    mpu_matrix_loader_if #(.N(N), .W(W)) bus ();

    mpu_matrix_loader #(.N(N), .W(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .elem_count  (elem_count),
        .frame_error (frame_error)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: the elements of the current frame, whether it is held, and the error pulse.
    logic [7:0] m_q[$];
    bit         m_full = 1'b0;
    bit         m_err  = 1'b0;

    function automatic logic [MW-1:0] model_matrix();
        logic [MW-1:0] r = '0;
        foreach (m_q[k]) r[W*k +: W] = m_q[k];
        return r;
    endfunction

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        if (reset) begin
            m_q.delete();
            m_full = 1'b0;
            m_err  = 1'b0;
        end else if (!m_full) begin
            m_err = 1'b0;
            if (bus.in_valid) begin
                m_q.push_back(bus.in_data);
                if (bus.in_last || m_q.size() == NE) begin
                    m_full = 1'b1;
                    m_err  = !bus.in_last;
                end
            end
        end else begin
            m_err = 1'b0;
            if (bus.out_ready) begin
                m_q.delete();
                m_full = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        check("in_ready",    MW'(bus.in_ready),  MW'(!m_full));
        check("out_valid",   MW'(bus.out_valid), MW'(m_full));
        check("matrix",      bus.matrix,         model_matrix());
        check("elem_count",  MW'(elem_count),    MW'(m_q.size()));
        check("frame_error", MW'(frame_error),   MW'(m_err));
    endtask

    logic [7:0] pat [6];
    int         rise1;
    int         rise2;
    int         nrise;
    bit         prev_ov;

    initial begin
        pat = '{8'h02, 8'hFF, 8'h00, 8'h04, 8'h05, 8'h0C};
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();

        // Full frame with in_last on the 25th element
        bus.out_ready = 1'b1;
        for (int k = 0; k < NE; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (k < 6) ? pat[k] : ((k == NE - 1) ? 8'h01 : 8'($urandom));
            bus.in_last  = (k == NE - 1);
            step();
        end
        check("full_valid", MW'(bus.out_valid),  MW'(1'b1));
        check("full_e0",    MW'(bus.matrix[7:0]),     MW'(8'h02));
        check("full_e1",    MW'(bus.matrix[15:8]),    MW'(8'hFF));
        check("full_e24",   MW'(bus.matrix[199:192]), MW'(8'h01));
        check("full_ferr",  MW'(frame_error),         MW'(1'b0));
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        step();
        check("full_ready_back", MW'(bus.in_ready), MW'(1'b1));

        // Short frame followed by output backpressure
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(7 + k);
            bus.in_last  = (k == 2);
            step();
        end
        check("short_matrix", bus.matrix,       MW'(24'h090807));
        check("short_count",  MW'(elem_count),  MW'(5'd3));
        bus.in_last = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.in_data = 8'($urandom);
            step();
        end
        check("bp_matrix", bus.matrix,        MW'(24'h090807));
        check("bp_ready",  MW'(bus.in_ready), MW'(1'b0));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();

        // Overrun: 25 elements with no in_last, 26th held off until the handshake
        bus.out_ready = 1'b0;
        for (int k = 0; k < NE; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            bus.in_last  = 1'b0;
            step();
        end
        check("ovr_ferr_on", MW'(frame_error), MW'(1'b1));
        bus.in_data = 8'hA5;
        step();
        check("ovr_ferr_off", MW'(frame_error), MW'(1'b0));
        check("ovr_count",    MW'(elem_count),  MW'(5'd25));
        step();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        step();
        check("ovr_next_slot0", MW'(bus.matrix[7:0]), MW'(8'hA5));
        bus.in_valid = 1'b0;
        step();

        // Randomized traffic on both sides
        for (int k = 0; k < 400; k++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = 8'($urandom);
            bus.in_last   = ($urandom_range(0, 9) == 0);
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end

        // Reset in the middle of a frame, colliding with an accept
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        step();
        step();
        bus.out_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            bus.in_last  = 1'b0;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_matrix", bus.matrix,         MW'(1'b0));
        check("rst_count",  MW'(elem_count),    MW'(1'b0));
        check("rst_ready",  MW'(bus.in_ready),  MW'(1'b1));
        check("rst_valid",  MW'(bus.out_valid), MW'(1'b0));
        for (int k = 0; k < NE; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            bus.in_last  = (k == NE - 1);
            step();
        end
        check("rst_reload_valid", MW'(bus.out_valid), MW'(1'b1));
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        step();

        // Back-to-back frames with both sides always willing
        rise1   = 0;
        rise2   = 0;
        nrise   = 0;
        prev_ov = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            bus.in_data = 8'($urandom);
            bus.in_last = (m_q.size() == NE - 1) && !m_full;
            step();
            if (bus.out_valid && !prev_ov) begin
                if (nrise == 0) rise1 = cyc;
                else if (nrise == 1) rise2 = cyc;
                nrise++;
            end
            prev_ov = bus.out_valid;
        end
        check("b2b_period", MW'(rise2 - rise1), MW'(26));
        bus.in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
